ws2812_tx: RTL and testbench

Serial output stage for the WS2812 chain: receives per-LED write transactions from the WS2812 data controller (`write`, `rgb_data`, `address`), stores them in an internal LED frame memory, and on request streams the whole frame onto the single-wire WS2812 data line with the NRZ bit timing and latch gap.

---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/ws2812_tx_if.sv | 24 ++
 rtl/ws2812_led_ram.sv | 26 ++
 rtl/ws2812_tx.sv | 161 ++++++++++++++++
 tb/tb_ws2812_tx.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 serial output stage.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int DEF_MAX_LEDS = 256;
  localparam int DEF_T0H      = 20;
  localparam int DEF_T1H      = 40;
  localparam int DEF_TBIT     = 63;
  localparam int DEF_TRESET   = 15000;

  localparam int RGB_W = 24;
  localparam int IDX_W = 16;

  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] req,
                                                 input logic [IDX_W-1:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/ws2812_tx_if.sv
// Bundle between the WS2812 data controller (master) and the serial output stage (slave).
interface ws2812_tx_if;
  import ws2812_pkg::*;

  logic             write;
  logic [RGB_W-1:0] rgb_data;
  logic [IDX_W-1:0] address;
  logic [IDX_W-1:0] num_leds;
  logic             refresh;
  logic             dout;
  logic             busy;
  logic             frame_done;

  modport master (
    output write, rgb_data, address, num_leds, refresh,
    input  dout, busy, frame_done
  );

  modport slave (
    input  write, rgb_data, address, num_leds, refresh,
    output dout, busy, frame_done
  );

endinterface

// File: rtl/ws2812_led_ram.sv
// LED frame memory: one write port, one registered read port, contents never reset.
module ws2812_led_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [23:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [23:0]   o_rdata
);

  logic [23:0] r_mem [DEPTH];
  logic [23:0] r_rdata;

  // A read and a write to the same address on one edge returns the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 serial output stage: stores per-LED colours and streams a frame as NRZ bits plus latch gap.
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int MAX_LEDS = DEF_MAX_LEDS,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TBIT     = DEF_TBIT,
  parameter int TRESET   = DEF_TRESET
) (
  input  logic        clk,
  input  logic        rst_n,
  ws2812_tx_if.slave  bus
);

  localparam int AW = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1;
  localparam int PW = $clog2(TBIT);
  localparam int LW = $clog2(TRESET + 1);

  localparam logic [PW-1:0]    PH_LAST    = PW'(TBIT - 1);
  localparam logic [PW-1:0]    HI0        = PW'(T0H);
  localparam logic [PW-1:0]    HI1        = PW'(T1H);
  localparam logic [LW-1:0]    LATCH_LAST = LW'(TRESET);
  localparam logic [IDX_W-1:0] LED_LIM    = IDX_W'(MAX_LEDS);

  state_t           r_state;
  state_t           w_state_next;
  logic [PW-1:0]    r_phase;
  logic [4:0]       r_bit;
  logic [IDX_W-1:0] r_led;
  logic [LW-1:0]    r_latch;
  logic [IDX_W-1:0] r_n;
  logic [23:0]      r_word;
  logic             r_pending;
  logic             r_dout;
  logic             r_busy;
  logic             r_frame_done;

  logic [IDX_W-1:0] w_n;
  logic             w_req;
  logic             w_bit_end;
  logic             w_frame_end;
  logic             w_latch_end;
  logic             w_led_start;
  logic             w_cur_bit;
  logic [PW-1:0]    w_hi_len;
  logic             w_dout_next;
  logic             w_re;
  logic [AW-1:0]    w_raddr;
  logic             w_we;
  logic [23:0]      w_rdata;

  ws2812_led_ram #(
    .DEPTH (MAX_LEDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (bus.address[AW-1:0]),
    .i_wdata (bus.rgb_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_we        = bus.write && (bus.address < LED_LIM);
  assign w_n         = clamp_len(bus.num_leds, LED_LIM);
  assign w_req       = bus.refresh | r_pending;
  assign w_bit_end   = (r_phase == PH_LAST);
  assign w_frame_end = w_bit_end && (r_bit == 5'd0) && (r_led == r_n - 16'd1);
  assign w_latch_end = (r_latch == LATCH_LAST);
  assign w_led_start = (r_bit == 5'd23) && (r_phase == '0);

  // On an LED's first cycle the word is still only in the RAM output register.
  assign w_cur_bit   = w_led_start ? w_rdata[23] : r_word[r_bit];
  assign w_hi_len    = w_cur_bit ? HI1 : HI0;
  assign w_dout_next = (r_state == SEND) && (r_phase < w_hi_len);

  // Prefetch the next LED during the first cycle of bit 0 so LEDs run back to back.
  assign w_re    = (r_state == LOAD) ||
                   ((r_state == SEND) && (r_bit == 5'd0) && (r_phase == '0));
  assign w_raddr = (r_state == LOAD) ? '0 : (r_led[AW-1:0] + AW'(1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req && (w_n != '0)) w_state_next = LOAD;
      LOAD:    w_state_next = SEND;
      SEND:    if (w_frame_end) w_state_next = LATCH;
      LATCH:   if (w_latch_end) w_state_next = (w_req && (w_n != '0)) ? LOAD : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_bit     <= 5'd23;
      r_led     <= '0;
      r_latch   <= '0;
      r_n       <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_state_next == LOAD) r_n <= w_n;

      if ((r_state == LATCH) && w_latch_end) r_pending <= 1'b0;
      else if (bus.refresh && r_busy)        r_pending <= 1'b1;

      unique case (r_state)
        LOAD: begin
          r_phase <= '0;
          r_bit   <= 5'd23;
          r_led   <= '0;
          r_latch <= '0;
        end
        SEND: begin
          if (w_bit_end) begin
            r_phase <= '0;
            if (r_bit == 5'd0) begin
              r_bit <= 5'd23;
              if (!w_frame_end) r_led <= r_led + 16'd1;
            end else begin
              r_bit <= r_bit - 5'd1;
            end
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        LATCH:   r_latch <= w_latch_end ? '0 : (r_latch + LW'(1));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == SEND) && w_led_start) r_word <= w_rdata;
  end

  // Output registers: dout lags the bit counters by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_dout       <= w_dout_next;
      r_busy       <= (w_state_next != IDLE);
      r_frame_done <= (r_state == LATCH) && w_latch_end;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ws2812_tx.sv
// Self-checking bench for ws2812_tx: decodes the dout waveform against a colour-memory model.
module tb_ws2812_tx;

  localparam int P_MAX  = 4;
  localparam int P_T0H  = 2;
  localparam int P_T1H  = 4;
  localparam int P_TBIT = 6;
  localparam int P_TRST = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   fd_count = 0;
  logic [23:0] mdl [P_MAX];

  ws2812_tx_if bus ();

  ws2812_tx #(
    .MAX_LEDS (P_MAX),
    .T0H      (P_T0H),
    .T1H      (P_T1H),
    .TBIT     (P_TBIT),
    .TRESET   (P_TRST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_count <= fd_count + 1;

  task automatic write_led(input logic [15:0] a, input logic [23:0] d);
    @(negedge clk);
    bus.write    = 1'b1;
    bus.address  = a;
    bus.rgb_data = d;
    if (a < 16'(P_MAX)) mdl[a[1:0]] = d;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
  endtask

  // Each LED's expected colour is whatever the model holds when that LED starts on the wire.
  task automatic check_frame(input int n, input logic exp_busy_end, input string tag,
                             output int waited);
    int bad;
    int ones;
    int exp_h;
    logic [23:0] w;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.dout !== 1'b1 && waited < 100);
    n_checks++;
    if (bus.dout !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rise: dout=%b after %0d cycles, required 1", tag, bus.dout, waited);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = mdl[i];
      for (int b = 23; b >= 0; b--) begin
        exp_h = w[b] ? P_T1H : P_T0H;
        bad = 0;
        ones = 0;
        for (int c = 0; c < P_TBIT; c++) begin
          if (!(i == 0 && b == 23 && c == 0)) @(negedge clk);
          if (bus.dout === 1'b1) ones++;
          if (bus.dout !== logic'(c < exp_h) || bus.busy !== 1'b1 || bus.frame_done !== 1'b0)
            bad++;
        end
        n_checks++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL %s led %0d bit %0d: high cycles %0d, required %0d (%0d bad samples)",
                   tag, i, b, ones, exp_h, bad);
        end
      end
    end
    bad = 0;
    for (int c = 0; c < P_TRST; c++) begin
      @(negedge clk);
      if (bus.dout !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s latch gap: %0d bad samples, required 0", tag, bad);
    end
    @(negedge clk);
    n_checks++;
    if (bus.frame_done !== 1'b1 || bus.busy !== exp_busy_end || bus.dout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s frame_done edge: frame_done=%b busy=%b dout=%b, required 1 %b 0",
               tag, bus.frame_done, bus.busy, bus.dout, exp_busy_end);
    end
    @(negedge clk);
    n_checks++;
    if (bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s frame_done width: frame_done=%b one cycle later, required 0",
               tag, bus.frame_done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.dout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: dout=%b busy=%b frame_done=%b, required 000",
               bus.dout, bus.busy, bus.frame_done);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.dout !== 1'b0) begin
      n_fail++;
      $display("FAIL idle after reset: busy=%b dout=%b, required 00", bus.busy, bus.dout);
    end
  endtask

  task automatic test_single_led();
    int waited;
    int fd0;
    write_led(16'd0, 24'hA50F00);
    bus.num_leds = 16'd1;
    fd0 = fd_count;
    pulse_refresh();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.dout !== 1'b0) begin
      n_fail++;
      $display("FAIL single busy rise: busy=%b dout=%b, required 1 0", bus.busy, bus.dout);
    end
    check_frame(1, 1'b0, "single", waited);
    n_checks++;
    if (waited != 2) begin
      n_fail++;
      $display("FAIL single latency: dout rose %0d cycles after busy, required 2", waited);
    end
    n_checks++;
    if (fd_count - fd0 != 1) begin
      n_fail++;
      $display("FAIL single frame_done count: %0d, required 1", fd_count - fd0);
    end
  endtask

  task automatic test_multi_led();
    int waited;
    for (int i = 0; i < 3; i++)
      write_led(16'(i), {8'(i * 37 + 11), 16'($urandom)});
    bus.num_leds = 16'd3;
    pulse_refresh();
    check_frame(3, 1'b0, "multi", waited);
  endtask

  task automatic test_back_to_back();
    int waited;
    int fd0;
    int bad;
    for (int i = 0; i < 2; i++) write_led(16'(i), 24'($urandom));
    bus.num_leds = 16'd2;
    fd0 = fd_count;
    pulse_refresh();
    fork
      check_frame(2, 1'b1, "pend1", waited);
      begin
        repeat (20) @(negedge clk);
        pulse_refresh();
        repeat (60) @(negedge clk);
        pulse_refresh();
      end
    join
    check_frame(2, 1'b0, "pend2", waited);
    n_checks++;
    if (waited != 1) begin
      n_fail++;
      $display("FAIL pend restart: dout rose %0d cycles after prior pulse, required 1", waited);
    end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.dout !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pend no third frame: %0d busy/dout samples, required 0", bad);
    end
    n_checks++;
    if (fd_count - fd0 != 2) begin
      n_fail++;
      $display("FAIL pend frame_done count: %0d, required 2", fd_count - fd0);
    end
  endtask

  task automatic test_midframe_write();
    int waited;
    for (int i = 0; i < 2; i++) write_led(16'(i), 24'($urandom));
    bus.num_leds = 16'd2;
    pulse_refresh();
    fork
      check_frame(2, 1'b0, "midwr", waited);
      begin
        repeat (30) @(negedge clk);
        write_led(16'd1, 24'($urandom));
        write_led(16'd7, 24'($urandom));
        write_led(16'd5, 24'($urandom));
        repeat (150) @(negedge clk);
        write_led(16'd0, 24'($urandom));
      end
    join
    pulse_refresh();
    check_frame(2, 1'b0, "midwr_next", waited);
  endtask

  task automatic test_zero_and_clamp();
    int waited;
    int bad;
    bus.num_leds = 16'd0;
    pulse_refresh();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.dout !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL zero leds: %0d busy/dout samples, required 0", bad);
    end
    for (int i = 0; i < P_MAX; i++) write_led(16'(i), 24'($urandom));
    bus.num_leds = 16'd9;
    pulse_refresh();
    check_frame(P_MAX, 1'b0, "clamp", waited);
  endtask

  task automatic test_async_reset();
    int waited;
    int t;
    bus.num_leds = 16'd2;
    pulse_refresh();
    t = 0;
    while (bus.dout !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (bus.dout !== 1'b1) begin
      n_fail++;
      $display("FAIL areset setup: dout=%b, required 1", bus.dout);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.dout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset immediate: dout=%b busy=%b frame_done=%b, required 000",
               bus.dout, bus.busy, bus.frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.dout !== 1'b0) begin
      n_fail++;
      $display("FAIL areset idle: busy=%b dout=%b, required 00", bus.busy, bus.dout);
    end
    pulse_refresh();
    check_frame(2, 1'b0, "areset_frame", waited);
  endtask

  initial begin
    bus.write    = 1'b0;
    bus.rgb_data = '0;
    bus.address  = '0;
    bus.num_leds = '0;
    bus.refresh  = 1'b0;
    test_reset();
    test_single_led();
    test_multi_led();
    test_back_to_back();
    test_midframe_write();
    test_zero_and_clamp();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
